// File: rtl/reception8.sv
// Reassembles an 8-bit word from bits delivered serially with a 3-bit position address.
// Bits must arrive in ascending order; an out-of-order bit or an over-long gap aborts the frame.
module reception8 #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iBit,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       iValid,
   output logic [7:0] oData,
   output logic       oValid,
   output logic       oErr,
   output logic       oBusy
);

   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t        state, state_nx;
   logic [2:0]    exp;
   logic [7:0]    sh;
   logic [IW-1:0] idle;
   logic          err_q;

   logic [2:0] idx;
   logic       start, hit, err_set;

   assign idx   = {A, B, C};
   assign start = iValid && (idx == 3'd0);
   assign hit   = iValid && (idx == exp);
   // Abort when a bit arrives out of order, or when this idle cycle would bring the count to TIMEOUT.
   assign err_set = (state == S_COLLECT) &&
                    ((iValid && (idx != exp)) || (!iValid && (idle == IDLE_LAST)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (start) state_nx = S_COLLECT;
         S_COLLECT: begin
            if (err_set)                   state_nx = S_IDLE;
            else if (hit && exp == 3'd7)   state_nx = S_DONE;
         end
         S_DONE:    state_nx = start ? S_COLLECT : S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      oValid = (state == S_DONE);
      oBusy  = (state == S_COLLECT);
      oErr   = err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh    <= '0;
         exp   <= '0;
         idle  <= '0;
         oData <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= err_set;
         if (err_set) begin
            sh   <= '0;
            exp  <= '0;
            idle <= '0;
         end else if (state != S_COLLECT && start) begin
            sh[0] <= iBit;
            exp   <= 3'd1;
            idle  <= '0;
         end else if (state == S_COLLECT && hit) begin
            sh[exp] <= iBit;
            exp     <= exp + 3'd1;
            idle    <= '0;
            if (exp == 3'd7) oData <= {iBit, sh[6:0]};
         end else if (state == S_COLLECT && !iValid) begin
            idle <= idle + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_reception8.sv
// Directed-vector bench for reception8: each vector drives one cycle of inputs and
// checks the outputs just after the following rising edge.
module tb_reception8;

   logic       clk = 1'b0;
   logic       rst;
   logic       iBit, A, B, C, iValid;
   logic [7:0] oData;
   logic       oValid, oErr, oBusy;

   int n_vec = 0;
   int n_bad = 0;

   reception8 #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .iBit(iBit), .A(A), .B(B), .C(C), .iValid(iValid),
      .oData(oData), .oValid(oValid), .oErr(oErr), .oBusy(oBusy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [2:0] idx;
      logic       b;
      logic       ev, ee, eb;
      logic [7:0] ed;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [2:0] idx, input logic b,
                      input logic ev, input logic ee, input logic eb, input logic [7:0] ed);
      vec_t t;
      t.v = v; t.idx = idx; t.b = b; t.ev = ev; t.ee = ee; t.eb = eb; t.ed = ed;
      tbl.push_back(t);
   endtask

   // One full in-order frame of word d, with gap idle cycles between bits; prev is oData before completion.
   task automatic add_frame(input logic [7:0] d, input logic [7:0] prev, input int gap);
      for (int i = 0; i < 8; i++) begin
         add(1'b1, 3'(i), d[i], i == 7, 1'b0, i != 7, (i == 7) ? d : prev);
         if (i < 7)
            for (int g = 0; g < gap; g++) add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, prev);
      end
   endtask

   task automatic check(input string name, input logic ev, input logic ee,
                        input logic eb, input logic [7:0] ed);
      n_vec++;
      if (oValid !== ev || oErr !== ee || oBusy !== eb || oData !== ed) begin
         n_bad++;
         $display("FAIL %s: got valid=%b err=%b busy=%b data=%h, want valid=%b err=%b busy=%b data=%h",
                  name, oValid, oErr, oBusy, oData, ev, ee, eb, ed);
      end
   endtask

   task automatic apply(input string name, input vec_t t);
      iValid = t.v;
      {A, B, C} = t.idx;
      iBit = t.b;
      @(posedge clk);
      #1;
      check(name, t.ev, t.ee, t.eb, t.ed);
   endtask

   initial begin
      vec_t t;
      logic [7:0] w;
      rst = 1'b1; iBit = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0; iValid = 1'b0;

      // In-order frame 0x0F
      add_frame(8'h0F, 8'h00, 0);
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
      // Non-zero index while idle is ignored silently
      add(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
      // Order error 0,1,3; oData keeps 0x0F
      add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
      add(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F);
      add(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F);
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
      add_frame(8'hAA, 8'h0F, 0);
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
      // Gapped frame, 3 idle cycles between bits
      add_frame(8'hAA, 8'hAA, 3);
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
      // Back-to-back: index 0 of the second frame lands in the DONE cycle
      add_frame(8'h0F, 8'hAA, 0);
      add_frame(8'hAA, 8'h0F, 0);
      // Non-zero index in DONE is ignored
      add(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
      // Mismatching index 0 mid-frame aborts and does not restart
      add(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
      add(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
      add(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
      add(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);

      #12;
      check("reset", 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[k]) apply($sformatf("vec%0d", k), tbl[k]);

      // Timeout: indices 0..2 then 16 idle cycles
      for (int i = 0; i < 3; i++) begin
         t.v = 1'b1; t.idx = 3'(i); t.b = 1'b1; t.ev = 1'b0; t.ee = 1'b0; t.eb = 1'b1; t.ed = 8'hAA;
         apply("to_bit", t);
      end
      for (int g = 1; g <= 16; g++) begin
         t.v = 1'b0; t.idx = 3'd0; t.b = 1'b0; t.ev = 1'b0;
         t.ee = (g == 16); t.eb = (g != 16); t.ed = 8'hAA;
         apply($sformatf("to_idle%0d", g), t);
      end
      t.ee = 1'b0; t.eb = 1'b0;
      apply("to_after", t);

      // Reset mid-frame after index 4, checked between clock edges
      for (int i = 0; i < 5; i++) begin
         t.v = 1'b1; t.idx = 3'(i); t.b = 1'b1; t.ev = 1'b0; t.ee = 1'b0; t.eb = 1'b1; t.ed = 8'hAA;
         apply("mid_bit", t);
      end
      #2 rst = 1'b1;
      #1 check("async_rst", 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         t.v = 1'b1; t.idx = 3'(i); t.b = w[i];
         t.ev = (i == 7); t.ee = 1'b0; t.eb = (i != 7); t.ed = (i == 7) ? w : 8'h00;
         apply("post_rst", t);
      end
      t.v = 1'b0; t.ev = 1'b0; t.eb = 1'b0; t.ed = 8'h3C;
      apply("post_rst_idle", t);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete, want completion");
      $fatal(1);
   end

endmodule

// File: doc/reception8.md
RECEPTION8 -- requirements
Module: reception8

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, the maximum idle cycles allowed between accepted bits within one frame.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port iBit, input, 1, serial data bit from the 8-to-1 selector end of the link.
REQ-005 SHALL provide ports A, B, C, input, 1 each, bit-position address with A as MSB and C as LSB; index = {A,B,C}.
REQ-006 SHALL provide port iValid, input, 1, qualifying iBit/A/B/C for the current cycle.
REQ-007 SHALL provide port oData, output, 8, the reassembled word; stable except when loaded at frame completion.
REQ-008 SHALL provide port oValid, output, 1, a one-cycle pulse marking a new oData word.
REQ-009 SHALL provide port oErr, output, 1, a one-cycle pulse marking an aborted frame.
REQ-010 SHALL provide port oBusy, output, 1, high while a frame is partially received.

Function
REQ-011 SHALL implement three states: IDLE, COLLECT and DONE.
REQ-012 SHALL keep a 3-bit expected-index counter exp, an 8-bit shadow register sh, and an idle counter of ceil(log2(TIMEOUT+1)) bits.
REQ-013 SHALL accept a bit only when iValid=1; iValid=0 cycles never change sh or exp.
REQ-014 SHALL require bits in ascending order: index 0, then 1, ... up to 7.
REQ-015 SHALL, in IDLE with iValid=1 and index=0, write sh[0]=iBit, set exp=1 and enter COLLECT.
REQ-016 SHALL, in IDLE with iValid=1 and index!=0, ignore the bit, stay in IDLE and leave oErr at 0.
REQ-017 SHALL, in COLLECT with iValid=1 and index==exp, write sh[index]=iBit, increment exp and clear the idle counter.
REQ-018 SHALL, in COLLECT when the accepted index is 7, enter DONE.
REQ-019 SHALL, on entering DONE, load oData={iBit,sh[6:0]} in the same clock edge as the index-7 bit.
REQ-020 SHALL assert oValid for exactly the single DONE cycle, then return to IDLE.
REQ-021 SHALL give oValid one cycle of latency after the clock edge that accepts the index-7 bit.
REQ-022 SHALL, in COLLECT with iValid=1 and index!=exp, pulse oErr for one cycle, clear sh and exp, and return to IDLE.
REQ-023 SHALL not restart a frame on the mismatching bit of REQ-022, even if its index is 0.
REQ-024 SHALL, in COLLECT, increment the idle counter on each iValid=0 cycle.
REQ-025 SHALL, when the idle counter reaches TIMEOUT, pulse oErr, clear sh and exp, and return to IDLE.
REQ-026 SHALL, in DONE, treat iValid=1 with index 0 as the start of a new frame, so that back-to-back frames are accepted without gaps.
REQ-027 SHALL, in DONE, ignore iValid=1 with any other index.
REQ-028 SHALL keep oData unchanged on error, timeout or ignored bits; oData changes only per REQ-019.
REQ-029 SHALL drive oBusy=1 exactly in COLLECT.
REQ-030 SHALL never assert oValid and oErr in the same cycle.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-frame, immediately force state=IDLE, exp=0, sh=0, idle counter=0, oData=8'h00, oValid=0, oErr=0 and oBusy=0.
REQ-032 SHALL, after rst deasserts, accept a new frame starting at index 0 on the first following clock edge.

Verification
REQ-033 SHALL cover in-order frame: indices 0..7 with iValid=1 on consecutive cycles, iBit per 8'b00001111 (bit i = iData[i]) -> oData=8'h0F, oValid single pulse one cycle after index 7, oErr never 1.
REQ-034 SHALL cover gapped frame: 8'b10101010 sent with 3 idle cycles between bits (below TIMEOUT) -> oData=8'hAA, one oValid pulse.
REQ-035 SHALL cover order error: indices 0,1,3 -> oErr pulse after index 3, oBusy falls, oData keeps its previous value, then a full 8'hAA frame -> oValid with 8'hAA.
REQ-036 SHALL cover timeout: indices 0..2 then iValid=0 for 16 cycles -> oErr pulse on the 16th idle cycle, state IDLE, no oValid.
REQ-037 SHALL cover back-to-back frames: frame 8'h0F immediately followed by frame 8'hAA with index 0 presented in the DONE cycle -> two oValid pulses 8 cycles apart, holding 8'h0F then 8'hAA.
REQ-038 SHALL cover reset mid-frame: rst pulsed after index 4 -> all outputs zero asynchronously, and a subsequent full frame is received correctly.
